count_ud_param: RTL and testbench

//  Parametrised synchronous up/down counter with parallel load, built as a

---
 rtl/count_pkg.sv | 12 +
 rtl/count_stage.sv | 44 ++++
 rtl/count_ud_param.sv | 74 +++++++
 tb/tb_count_ud_param.sv | 138 +++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared constants and helpers for the cascaded up/down counter.
package count_pkg;

  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  function automatic int unsigned cnt_width(input int unsigned stage_w,
                                            input int unsigned nstage);
    return stage_w * nstage;
  endfunction

endpackage

// File: rtl/count_stage.sv
// One loadable up/down counter slice; carries are resolved by the parent via en_up/en_dw.
module count_stage #(
  parameter int unsigned STAGE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STAGE_W-1:0] rst_val,
  input  logic [STAGE_W-1:0] din,
  input  logic               ld,
  input  logic               en_up,
  input  logic               en_dw,
  output logic [STAGE_W-1:0] q,
  output logic               utc,
  output logic               dtc
);

  localparam logic [STAGE_W-1:0] One = STAGE_W'(1);

  logic [STAGE_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = din;
    end else if (en_up && !en_dw) begin
      q_d = q_q + One;
    end else if (en_dw && !en_up) begin
      q_d = q_q - One;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign utc = &q_q;
  assign dtc = ~|q_q;

endmodule

// File: rtl/count_ud_param.sv
// Parametrised up/down counter: NSTAGE slices with ripple-enable carry, wrap or saturate.
module count_ud_param
  import count_pkg::*;
#(
  parameter int unsigned STAGE_W  = 5,
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned SATURATE = CNT_WRAP,
  parameter logic [cnt_width(STAGE_W, NSTAGE)-1:0] RESET_VAL = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [cnt_width(STAGE_W, NSTAGE)-1:0] din,
  input  logic                                   ld,
  input  logic                                   up,
  input  logic                                   dw,
  output logic [cnt_width(STAGE_W, NSTAGE)-1:0] q,
  output logic                                   utc,
  output logic                                   dtc,
  output logic                                   wrap
);

  localparam bit Sat = (SATURATE == CNT_SAT);

  logic [NSTAGE-1:0] s_utc, s_dtc;
  logic [NSTAGE-1:0] up_chain, dw_chain;
  logic              cnt_up, cnt_dw;
  logic              wrap_q, wrap_d;

  // Conflicting or absent requests hold; load wins over counting.
  assign cnt_up = up & ~dw & ~ld;
  assign cnt_dw = dw & ~up & ~ld;

  assign utc = &s_utc;
  assign dtc = &s_dtc;

  genvar k;
  for (k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign up_chain[k] = cnt_up & ~(Sat & utc);
      assign dw_chain[k] = cnt_dw & ~(Sat & dtc);
    end else begin : g_rest
      assign up_chain[k] = up_chain[k-1] & s_utc[k-1];
      assign dw_chain[k] = dw_chain[k-1] & s_dtc[k-1];
    end

    count_stage #(
      .STAGE_W(STAGE_W)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .rst_val(RESET_VAL[k*STAGE_W +: STAGE_W]),
      .din    (din[k*STAGE_W +: STAGE_W]),
      .ld     (ld),
      .en_up  (up_chain[k]),
      .en_dw  (dw_chain[k]),
      .q      (q[k*STAGE_W +: STAGE_W]),
      .utc    (s_utc[k]),
      .dtc    (s_dtc[k])
    );
  end

  assign wrap_d = ~Sat & ((cnt_up & utc) | (cnt_dw & dtc));

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_count_ud_param.sv
// Scoreboard bench: three counter variants (wrap, saturate, RESET_VAL=7) driven by directed vectors.
module tb_count_ud_param;

  localparam int W = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   rst_v, ld_v, up_v, dw_v;
  logic [W-1:0] din_v [3];
  logic [W-1:0] q_v   [3];
  logic [2:0]   utc_v, dtc_v, wrap_v;

  count_ud_param #(.STAGE_W(5), .NSTAGE(3), .SATURATE(0), .RESET_VAL(15'd0)) u_wrap (
    .clk(clk), .reset(rst_v[0]), .din(din_v[0]), .ld(ld_v[0]), .up(up_v[0]), .dw(dw_v[0]),
    .q(q_v[0]), .utc(utc_v[0]), .dtc(dtc_v[0]), .wrap(wrap_v[0])
  );
  count_ud_param #(.STAGE_W(5), .NSTAGE(3), .SATURATE(1), .RESET_VAL(15'd0)) u_sat (
    .clk(clk), .reset(rst_v[1]), .din(din_v[1]), .ld(ld_v[1]), .up(up_v[1]), .dw(dw_v[1]),
    .q(q_v[1]), .utc(utc_v[1]), .dtc(dtc_v[1]), .wrap(wrap_v[1])
  );
  count_ud_param #(.STAGE_W(5), .NSTAGE(3), .SATURATE(0), .RESET_VAL(15'd7)) u_rv (
    .clk(clk), .reset(rst_v[2]), .din(din_v[2]), .ld(ld_v[2]), .up(up_v[2]), .dw(dw_v[2]),
    .q(q_v[2]), .utc(utc_v[2]), .dtc(dtc_v[2]), .wrap(wrap_v[2])
  );

  typedef struct {
    int       id;
    logic [W-1:0] q;
    logic     utc;
    logic     dtc;
    logic     wrap;
    string    name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check1(input string nm, input string fld, input logic [W-1:0] act,
                        input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs settle one cycle after each request edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check1(e.name, "q",    q_v[e.id],               e.q);
        check1(e.name, "utc",  W'(utc_v[e.id]),  W'(e.utc));
        check1(e.name, "dtc",  W'(dtc_v[e.id]),  W'(e.dtc));
        check1(e.name, "wrap", W'(wrap_v[e.id]), W'(e.wrap));
      end
    end
  end

  task automatic step(input int id, input bit rst_all, input bit rst, input bit ld,
                      input bit up, input bit dw, input logic [W-1:0] din,
                      input logic [W-1:0] eq, input bit eu, input bit ed, input bit ew,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst_v = '0; ld_v = '0; up_v = '0; dw_v = '0;
    if (rst_all) begin
      rst_v = '1;
      up_v  = '1;
    end
    rst_v[id] = rst_v[id] | rst;
    ld_v[id]  = ld;
    up_v[id]  = up_v[id] | up;
    dw_v[id]  = dw;
    din_v[id] = din;
    e.id = id; e.q = eq; e.utc = eu; e.dtc = ed; e.wrap = ew; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_v = '1; ld_v = '0; up_v = '0; dw_v = '0;
    for (int i = 0; i < 3; i++) din_v[i] = '0;

    // Wrap-mode counter
    step(0, 1, 0, 0, 0, 0, 15'd0,     15'd0,     0, 1, 0, "rst1");
    step(0, 1, 0, 0, 0, 0, 15'd0,     15'd0,     0, 1, 0, "rst2");
    step(0, 0, 0, 1, 0, 0, 15'd31,    15'd31,    0, 0, 0, "ld31");
    step(0, 0, 0, 0, 1, 0, 15'd0,     15'd32,    0, 0, 0, "carry_s1");
    step(0, 0, 0, 0, 0, 1, 15'd0,     15'd31,    0, 0, 0, "borrow_s1");
    step(0, 0, 0, 1, 0, 0, 15'd1023,  15'd1023,  0, 0, 0, "ld1023");
    step(0, 0, 0, 0, 1, 0, 15'd0,     15'd1024,  0, 0, 0, "carry_s2");
    step(0, 0, 0, 0, 0, 1, 15'd0,     15'd1023,  0, 0, 0, "borrow_s2");
    step(0, 0, 0, 1, 0, 0, 15'd32767, 15'd32767, 1, 0, 0, "ld_max");
    step(0, 0, 0, 0, 1, 0, 15'd0,     15'd0,     0, 1, 1, "wrap_up");
    step(0, 0, 0, 0, 0, 1, 15'd0,     15'd32767, 1, 0, 1, "wrap_dw");
    step(0, 0, 0, 0, 0, 0, 15'd0,     15'd32767, 1, 0, 0, "hold_idle");
    step(0, 0, 0, 1, 1, 0, 15'd1000,  15'd1000,  0, 0, 0, "ld_over_up");
    step(0, 0, 0, 0, 1, 1, 15'd0,     15'd1000,  0, 0, 0, "hold_both");
    step(0, 0, 0, 0, 1, 0, 15'd0,     15'd1001,  0, 0, 0, "up_1001");
    step(0, 0, 0, 1, 0, 0, 15'd0,     15'd0,     0, 1, 0, "ld_zero_max_wrap");
    step(0, 0, 0, 1, 0, 1, 15'd5,     15'd5,     0, 0, 0, "ld_over_dw");

    // Saturating counter
    step(1, 0, 0, 1, 0, 0, 15'd32767, 15'd32767, 1, 0, 0, "sat_ld_max");
    step(1, 0, 0, 0, 1, 0, 15'd0,     15'd32767, 1, 0, 0, "sat_up1");
    step(1, 0, 0, 0, 1, 0, 15'd0,     15'd32767, 1, 0, 0, "sat_up2");
    step(1, 0, 0, 0, 1, 0, 15'd0,     15'd32767, 1, 0, 0, "sat_up3");
    step(1, 0, 0, 0, 0, 1, 15'd0,     15'd32766, 0, 0, 0, "sat_dw");
    step(1, 0, 0, 1, 0, 0, 15'd0,     15'd0,     0, 1, 0, "sat_ld0");
    step(1, 0, 0, 0, 0, 1, 15'd0,     15'd0,     0, 1, 0, "sat_dw0");
    step(1, 0, 0, 0, 1, 0, 15'd0,     15'd1,     0, 0, 0, "sat_up_from0");

    // RESET_VAL=7 counter
    step(2, 0, 0, 1, 0, 0, 15'd499,   15'd499,   0, 0, 0, "rv_ld499");
    step(2, 0, 0, 0, 1, 0, 15'd0,     15'd500,   0, 0, 0, "rv_up500");
    step(2, 0, 1, 0, 1, 0, 15'd0,     15'd7,     0, 0, 0, "rv_reset_mid");
    step(2, 0, 0, 1, 0, 0, 15'd32767, 15'd32767, 1, 0, 0, "rv_ld_max");
    step(2, 0, 1, 1, 1, 0, 15'd100,   15'd7,     0, 0, 0, "rv_reset_over_ld_up");
    step(2, 0, 0, 0, 0, 1, 15'd0,     15'd6,     0, 0, 0, "rv_dw6");

    @(negedge clk);
    rst_v = '0; ld_v = '0; up_v = '0; dw_v = '0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
